// File: rtl/if_stage.sv
// Instruction-fetch stage: drives a request/ready instruction memory and
// loads the IF/ID pipeline register. A one-entry hold buffer keeps a word
// that arrives during a decode stall. DRAIN waits out a request that was
// still in flight when a redirect arrived, so its stale data is dropped.
//
// state | meaning
// IDLE  | after reset; start fetching at PC on the next clock
// FETCH | request outstanding at the fetch address
// HOLD  | word parked in the hold buffer while decode stalls; no request
// DRAIN | redirect taken; waiting for the old request to finish, data dropped
module if_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Stall,
  input  logic                  PCSource,
  input  logic [DATA_WIDTH-1:0] ID_PC,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  imem_ready,
  output logic [DATA_WIDTH-1:0] instructions,
  output logic [DATA_WIDTH-1:0] IF_ID_PC,
  output logic                  IF_ID_valid,
  output logic [DATA_WIDTH-1:0] PC
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] faddr_q;
  logic                  req_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] ifid_pc_q;
  logic                  ifid_vld_q;
  logic [DATA_WIDTH-1:0] hold_q;

  logic [DATA_WIDTH-1:0] pc_plus1_d;
  logic                  redirect_d;

  // Stall masks a redirect; PC+1 wraps naturally at the word-address width.
  assign pc_plus1_d = pc_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  assign redirect_d = PCSource && !Stall;

  // Fetch FSM with registered request, address and IF/ID outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      faddr_q    <= RESET_PC;
      req_q      <= 1'b0;
      instr_q    <= '0;
      ifid_pc_q  <= '0;
      ifid_vld_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          faddr_q <= pc_q;
          req_q   <= 1'b1;
        end

        FETCH: begin
          if (redirect_d) begin
            pc_q       <= ID_PC;
            instr_q    <= '0;
            ifid_pc_q  <= '0;
            ifid_vld_q <= 1'b0;
            hold_q     <= '0;
            // A completed request can be replaced at once; an open one must drain.
            if (imem_ready) begin
              faddr_q <= ID_PC;
            end else begin
              state_q <= DRAIN;
            end
          end else if (imem_ready && !Stall) begin
            instr_q    <= imem_data;
            ifid_pc_q  <= pc_plus1_d;
            ifid_vld_q <= 1'b1;
            pc_q       <= pc_plus1_d;
            faddr_q    <= pc_plus1_d;
          end else if (imem_ready) begin
            hold_q  <= imem_data;
            state_q <= HOLD;
            req_q   <= 1'b0;
          end else if (!Stall) begin
            instr_q    <= '0;
            ifid_vld_q <= 1'b0;
          end
        end

        HOLD: begin
          if (!Stall) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
            hold_q  <= '0;
            if (PCSource) begin
              pc_q       <= ID_PC;
              faddr_q    <= ID_PC;
              instr_q    <= '0;
              ifid_pc_q  <= '0;
              ifid_vld_q <= 1'b0;
            end else begin
              instr_q    <= hold_q;
              ifid_pc_q  <= pc_plus1_d;
              ifid_vld_q <= 1'b1;
              pc_q       <= pc_plus1_d;
              faddr_q    <= pc_plus1_d;
            end
          end
        end

        DRAIN: begin
          // The latest redirect target wins; the draining word is never used.
          if (redirect_d) begin
            pc_q <= ID_PC;
            if (imem_ready) begin
              faddr_q <= ID_PC;
              state_q <= FETCH;
            end
          end else if (imem_ready) begin
            faddr_q <= pc_q;
            state_q <= FETCH;
          end
        end

        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = faddr_q;
  assign instructions = instr_q;
  assign IF_ID_PC     = ifid_pc_q;
  assign IF_ID_valid  = ifid_vld_q;
  assign PC           = pc_q;

endmodule
